// File: rtl/sr_drive_pkg.sv
// Shared types and width helpers for the NAND SR-latch driver.
package sr_drive_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_PULSE = 2'd1,
        RST_PULSE = 2'd2,
        GAP       = 2'd3
    } drive_state_t;

    // Down-counter width: must hold the larger of the pulse and gap lengths.
    function automatic int cnt_width(input int pulse_width, input int gap_cycles);
        int m;
        m = (pulse_width > gap_cycles) ? pulse_width : gap_cycles;
        return $clog2(m + 1);
    endfunction

    // Debounce counter runs 0..DEBOUNCE_CYCLES-1; keep at least one bit.
    function automatic int db_width(input int debounce_cycles);
        return (debounce_cycles < 2) ? 1 : $clog2(debounce_cycles);
    endfunction

endpackage

// File: rtl/sr_drive_ctrl_debounce.sv
// Synchronizer + debounce + registered rising-edge strobe for one raw request.
// The strobe fires on the same edge the debounced level rises.
module sr_debounce
    import sr_drive_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic rise
);

    localparam int DB_W = db_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic                   db_level;
    logic                   synced;
    logic                   differs;
    logic                   flip;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign differs = (synced != db_level);
    assign flip    = differs && (db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            db_cnt   <= '0;
            db_level <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req};
            if (!differs || flip) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            if (flip) begin
                db_level <= synced;
            end
            rise <= flip && synced;
        end
    end

endmodule

// File: rtl/sr_drive_ctrl.sv
// Drives clean, mutually exclusive active-low Sbar/Rbar pulses from bouncy set/reset requests.
// Optional q_est (expected latch Q) output is enabled by defining SR_DRIVE_QEST_EN.
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_WIDTH     = 3,
    parameter int GAP_CYCLES      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic reset_req,
    output logic sbar,
    output logic rbar,
    output logic busy,
    output logic conflict
`ifdef SR_DRIVE_QEST_EN
    ,
    output logic q_est
`endif
);

    localparam int CNT_W = cnt_width(PULSE_WIDTH, GAP_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    logic s_rise;
    logic r_rise;

    drive_state_t     state;
    drive_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pend_s;
    logic             pend_s_nxt;
    logic             pend_r;
    logic             pend_r_nxt;

    logic sbar_nxt;
    logic rbar_nxt;
    logic busy_nxt;

    sr_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_set (
        .clk (clk),
        .rst (rst),
        .req (set_req),
        .rise(s_rise)
    );

    sr_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_reset (
        .clk (clk),
        .rst (rst),
        .req (reset_req),
        .rise(r_rise)
    );

    // Outputs are flopped from the next state so the latch inputs never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_s   <= 1'b0;
            pend_r   <= 1'b0;
            sbar     <= 1'b1;
            rbar     <= 1'b1;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pend_s   <= pend_s_nxt;
            pend_r   <= pend_r_nxt;
            sbar     <= sbar_nxt;
            rbar     <= rbar_nxt;
            busy     <= busy_nxt;
            conflict <= s_rise && r_rise;
        end
    end

    // Reset requests win; a losing or early request waits in a one-deep flag.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pend_s_nxt = pend_s || s_rise;
        pend_r_nxt = pend_r || r_rise;
        case (state)
            IDLE: begin
                if (r_rise || pend_r) begin
                    state_nxt  = RST_PULSE;
                    cnt_nxt    = PULSE_LOAD;
                    pend_r_nxt = 1'b0;
                end else if (s_rise || pend_s) begin
                    state_nxt  = SET_PULSE;
                    cnt_nxt    = PULSE_LOAD;
                    pend_s_nxt = 1'b0;
                end
            end
            SET_PULSE, RST_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        sbar_nxt = (state_nxt != SET_PULSE);
        rbar_nxt = (state_nxt != RST_PULSE);
        busy_nxt = (state_nxt != IDLE);
    end

`ifdef SR_DRIVE_QEST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            q_est <= 1'b0;
        end else if (state == SET_PULSE && state_nxt == GAP) begin
            q_est <= 1'b1;
        end else if (state == RST_PULSE && state_nxt == GAP) begin
            q_est <= 1'b0;
        end
    end
`endif

endmodule
